// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds and a
// selectable standard or first-word-fall-through read port. Define FIFO_ERR_FLAGS_EN for sticky overflow/underflow flags.
module sync_fifo_thresh #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  full_o,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE        = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] LVL_FULL   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = AEMPTY_THRESH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  wr_acc, rd_acc, prefetch;

  always_comb begin
    wr_acc      = wr_en_i & ~full_q & ~clr_i;
    rd_acc      = rd_en_i & ~empty_q & ~clr_i;
    prefetch    = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_data_d   = rd_data_q;
    out_valid_d = out_valid_q;
    empty_d     = empty_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
    if (wr_acc && !rd_acc)      level_d = level_q + ONE;
    else if (!wr_acc && rd_acc) level_d = level_q - ONE;

    if (FWFT != 0) begin
      // Refill the output register whenever it is empty or being popped and memory holds a word.
      prefetch = (wr_ptr_q != rd_ptr_q) && (!out_valid_q || rd_acc);
      if (prefetch) begin
        rd_data_d   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        rd_ptr_d    = rd_ptr_q + ONE;
        out_valid_d = 1'b1;
      end else if (rd_acc) begin
        out_valid_d = 1'b0;
      end
      empty_d = ~out_valid_d;
    end else begin
      if (rd_acc) begin
        rd_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        rd_ptr_d  = rd_ptr_q + ONE;
      end
      empty_d = (level_d == '0);
    end

    full_d   = (level_d == LVL_FULL);
    afull_d  = (level_d >= AFULL_LVL);
    aempty_d = (level_d <= AEMPTY_LVL);

    if (clr_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      rd_data_d   = '0;
      out_valid_d = 1'b0;
      empty_d     = 1'b1;
      full_d      = 1'b0;
      afull_d     = 1'b0;
      aempty_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      out_valid_q <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_data_q   <= rd_data_d;
      out_valid_q <= out_valid_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data_i;
  end

  assign rd_data_o      = rd_data_q;
  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign level_o        = level_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (wr_en_i & full_q);
    underflow_d = underflow_q | (rd_en_i & empty_q);
    if (clr_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Bench for sync_fifo_thresh: a standard and an FWFT instance share one stimulus
// stream and are both checked every cycle against queue-based models.
module tb_sync_fifo_thresh;

   localparam int DEPTH = 16;
`ifdef FIFO_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, clr, wrEn, rdEn;
   logic [15:0] wrData;

   logic full0, empty0, af0, ae0, ovf0, udf0;
   logic [15:0] rdData0;
   logic [4:0] level0;
   logic full1, empty1, af1, ae1, ovf1, udf1;
   logic [15:0] rdData1;
   logic [4:0] level1;

   int compared = 0;
   int mismatched = 0;
   bit checkEn = 1'b0;

   // Reference state: the standard FIFO is just a queue plus the last popped word;
   // the FWFT FIFO is a memory queue plus a one-word presentation slot.
   logic [15:0] stdQ[$];
   logic [15:0] stdData;
   bit stdOvf, stdUdf;
   logic [15:0] fwMem[$];
   bit fwValid;
   logic [15:0] fwData;
   bit fwOvf, fwUdf;

   sync_fifo_thresh #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .AFULL_THRESH(14),
                      .AEMPTY_THRESH(2), .FWFT(0)) dutStd (
      .clk_i(clk), .rst_i(rst), .clr_i(clr),
      .wr_en_i(wrEn), .wr_data_i(wrData), .full_o(full0),
      .rd_en_i(rdEn), .rd_data_o(rdData0), .empty_o(empty0),
      .level_o(level0), .almost_full_o(af0), .almost_empty_o(ae0),
      .overflow_o(ovf0), .underflow_o(udf0));

   sync_fifo_thresh #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .AFULL_THRESH(14),
                      .AEMPTY_THRESH(2), .FWFT(1)) dutFw (
      .clk_i(clk), .rst_i(rst), .clr_i(clr),
      .wr_en_i(wrEn), .wr_data_i(wrData), .full_o(full1),
      .rd_en_i(rdEn), .rd_data_o(rdData1), .empty_o(empty1),
      .level_o(level1), .almost_full_o(af1), .almost_empty_o(ae1),
      .overflow_o(ovf1), .underflow_o(udf1));

   always #5 clk = ~clk;

   // One comparison: bump the counters and report a mismatch on a single line.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic resetModels();
      stdQ.delete();
      stdData = '0;
      stdOvf = 1'b0;
      stdUdf = 1'b0;
      fwMem.delete();
      fwValid = 1'b0;
      fwData = '0;
      fwOvf = 1'b0;
      fwUdf = 1'b0;
   endtask

   // Advance both models by one clock edge using the inputs the DUTs just sampled.
   task automatic modelUpdate();
      int stdLvl, fwLvl;
      bit stdW, stdR, fwW, fwR;
      if (clr) begin
         resetModels();
      end else begin
         stdLvl = stdQ.size();
         if (wrEn && stdLvl == DEPTH) stdOvf = 1'b1;
         if (rdEn && stdLvl == 0) stdUdf = 1'b1;
         stdR = rdEn && (stdLvl > 0);
         stdW = wrEn && (stdLvl < DEPTH);
         if (stdR) stdData = stdQ.pop_front();
         if (stdW) stdQ.push_back(wrData);

         fwLvl = fwMem.size() + int'(fwValid);
         if (wrEn && fwLvl == DEPTH) fwOvf = 1'b1;
         if (rdEn && !fwValid) fwUdf = 1'b1;
         fwR = rdEn && fwValid;
         fwW = wrEn && (fwLvl < DEPTH);
         if (fwR) fwValid = 1'b0;
         if (!fwValid && fwMem.size() > 0) begin
            fwData = fwMem.pop_front();
            fwValid = 1'b1;
         end
         if (fwW) fwMem.push_back(wrData);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, advance the models, then idle the inputs.
   task automatic applyStimulus(input bit w, input logic [15:0] d, input bit r, input bit c);
      wrEn = w;
      wrData = d;
      rdEn = r;
      clr = c;
      @(posedge clk);
      modelUpdate();
      #1;
      wrEn = 1'b0;
      rdEn = 1'b0;
      clr = 1'b0;
   endtask

   // Compare every output of both instances against the models, half a cycle after each edge.
   always @(negedge clk) begin
      int sl, fl;
      if (checkEn) begin
         sl = stdQ.size();
         fl = fwMem.size() + int'(fwValid);
         checkOutput("std.level", 32'(level0), 32'(sl));
         checkOutput("std.empty", 32'(empty0), 32'(sl == 0));
         checkOutput("std.full", 32'(full0), 32'(sl == DEPTH));
         checkOutput("std.afull", 32'(af0), 32'(sl >= 14));
         checkOutput("std.aempty", 32'(ae0), 32'(sl <= 2));
         checkOutput("std.rdata", 32'(rdData0), 32'(stdData));
         checkOutput("std.ovf", 32'(ovf0), 32'(ERR_EN & stdOvf));
         checkOutput("std.udf", 32'(udf0), 32'(ERR_EN & stdUdf));
         checkOutput("fw.level", 32'(level1), 32'(fl));
         checkOutput("fw.empty", 32'(empty1), 32'(!fwValid));
         checkOutput("fw.full", 32'(full1), 32'(fl == DEPTH));
         checkOutput("fw.afull", 32'(af1), 32'(fl >= 14));
         checkOutput("fw.aempty", 32'(ae1), 32'(fl <= 2));
         checkOutput("fw.rdata", 32'(rdData1), 32'(fwData));
         checkOutput("fw.ovf", 32'(ovf1), 32'(ERR_EN & fwOvf));
         checkOutput("fw.udf", 32'(udf1), 32'(ERR_EN & fwUdf));
      end
   end

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      wrEn = 1'b0;
      rdEn = 1'b0;
      wrData = '0;
      resetModels();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset values pinned by hand.
      checkOutput("lit.reset.level", 32'(level0), 32'd0);
      checkOutput("lit.reset.empty", 32'(empty0), 32'd1);
      checkOutput("lit.reset.aempty", 32'(ae0), 32'd1);
      checkOutput("lit.reset.afull", 32'(af0), 32'd0);
      checkOutput("lit.reset.rdata", 32'(rdData1), 32'd0);
      checkEn = 1'b1;

      // Fill then drain the standard instance, checking thresholds at their crossings.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
         checkOutput("lit.fill.level", 32'(level0), 32'(i + 1));
         checkOutput("lit.fill.afull", 32'(af0), 32'(i >= 13));
      end
      checkOutput("lit.fill.full", 32'(full0), 32'd1);
      applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0);
      checkOutput("lit.fill.extra", 32'(level0), 32'd16);
      for (int j = 0; j < 16; j++) begin
         applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
         checkOutput("lit.drain.rdata", 32'(rdData0), 32'(j));
         checkOutput("lit.drain.aempty", 32'(ae0), 32'((15 - j) <= 2));
      end
      checkOutput("lit.drain.empty", 32'(empty0), 32'd1);

      // FWFT latency: the word appears one edge after the write edge.
      applyStimulus(1'b1, 16'hA5A5, 1'b0, 1'b0);
      checkOutput("lit.fwft.prefetch_empty", 32'(empty1), 32'd1);
      checkOutput("lit.fwft.prefetch_level", 32'(level1), 32'd1);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("lit.fwft.empty", 32'(empty1), 32'd0);
      checkOutput("lit.fwft.rdata", 32'(rdData1), 32'hA5A5);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("lit.fwft.pop_empty", 32'(empty1), 32'd1);
      checkOutput("lit.fwft.pop_level", 32'(level1), 32'd0);
      checkOutput("lit.fwft.hold", 32'(rdData1), 32'hA5A5);

      // Steady read+write at level 8, then read+write while full.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'($urandom()), 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 16'($urandom()), 1'b1, 1'b0);
      checkOutput("lit.rw8.std", 32'(level0), 32'd8);
      checkOutput("lit.rw8.fw", 32'(level1), 32'd8);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'($urandom()), 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h5A5A, 1'b1, 1'b0);
      checkOutput("lit.rwfull.std", 32'(level0), 32'd15);
      checkOutput("lit.rwfull.fw", 32'(level1), 32'd15);

      // Random traffic from empty, long enough to wrap the pointers.
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
      for (int i = 0; i < 60; i++)
         applyStimulus($urandom_range(0, 99) < 70, 16'($urandom()), $urandom_range(0, 99) < 50, 1'b0);

      // Clear at level 9 with a simultaneous read and write, both discarded.
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 16'(i + 100), 1'b0, 1'b0);
      checkOutput("lit.clr.pre", 32'(level0), 32'd9);
      applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b1);
      checkOutput("lit.clr.level", 32'(level0), 32'd0);
      checkOutput("lit.clr.empty", 32'(empty1), 32'd1);
      checkOutput("lit.clr.rdata0", 32'(rdData0), 32'd0);
      checkOutput("lit.clr.rdata1", 32'(rdData1), 32'd0);

      // Asynchronous reset in the middle of a write cycle.
      applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h6666, 1'b1, 1'b0);
      wrEn = 1'b1;
      wrData = 16'h7777;
      #2;
      rst = 1'b1;
      resetModels();
      #1;
      checkOutput("lit.rst.level", 32'(level1), 32'd0);
      checkOutput("lit.rst.empty", 32'(empty0), 32'd1);
      checkOutput("lit.rst.rdata0", 32'(rdData0), 32'd0);
      checkOutput("lit.rst.rdata1", 32'(rdData1), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      wrEn = 1'b0;
      applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("lit.after.fw", 32'(rdData1), 32'h1234);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("lit.after.std", 32'(rdData0), 32'h1234);

      // Error flags: overflow survives a drain, underflow on empty read, clear wipes both.
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 16'(i + 200), 1'b0, 1'b0);
      applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
      checkOutput("lit.err.ovf", 32'(ovf0), 32'(ERR_EN));
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("lit.err.ovf_sticky", 32'(ovf0), 32'(ERR_EN));
      checkOutput("lit.err.udf_clean", 32'(udf0), 32'd0);
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("lit.err.udf", 32'(udf0), 32'(ERR_EN));
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
      checkOutput("lit.err.clr_ovf", 32'(ovf1), 32'd0);
      checkOutput("lit.err.clr_udf", 32'(udf1), 32'd0);

      repeat (2) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
      checkEn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
